// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the MAR/MDR memory responder and its datapath peers:
// responder FSM state encoding, request op encoding and default bus widths.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int MEM_ADDR_W = 9;   // word-address bits decoded from MAR
    localparam int MEM_DATA_W = 32;  // MDR / memory word width
    localparam int MAR_W      = 32;  // full MAR register width
    localparam int CNT_W      = 4;   // wait-state counter width (0..15)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Read has priority: with both strobes high the write is dropped.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd || !wr) begin
            return OP_READ;
        end
        return OP_WRITE;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the control datapath (master) and the
// memory responder (slave).
//   MAR_q    master->slave  address from MAR
//   MDR_q    master->slave  write data from MDR
//   Read     master->slave  read request strobe
//   Write    master->slave  write request strobe
//   Mdatain  slave->master  read data to the MDR input mux
//   Mem_done slave->master  one-cycle transaction-complete pulse
//   Mem_err  slave->master  address-range error, valid with Mem_done
// -----------------------------------------------------------------------------
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
);
    logic [MAR_W-1:0]  MAR_q;
    logic [DATA_W-1:0] MDR_q;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] Mdatain;
    logic              Mem_done;
    logic              Mem_err;

    modport master (
        output MAR_q, MDR_q, Read, Write,
        input  Mdatain, Mem_done, Mem_err
    );

    modport slave (
        input  MAR_q, MDR_q, Read, Write,
        output Mdatain, Mem_done, Mem_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, with a registered read port.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high clear of the read register only
//   we       in   write enable (wdata -> mem[addr])
//   re       in   read enable (mem[addr] -> rdata register)
//   rd_zero  in   with re, load zero instead of the array word
//   addr     in   word address
//   wdata    in   write data
//   rdata    out  registered read data, held until the next read
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array storage is never cleared so it maps onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= rd_zero ? '0 : r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-addressed memory answering MAR/MDR read/write requests after a fixed
// number of wait states, closing each transaction with a Mem_done pulse.
//   Clock  in   sole clock, rising edge
//   clr    in   synchronous active-high reset
//   bus    slave modport of mem_responder_if (MAR_q, MDR_q, Read, Write in;
//          Mdatain, Mem_done, Mem_err out)
// Optional build macro MEM_ADDR_CHECK_EN: when defined, a request with any
// MAR_q bit above ADDR_W set raises Mem_err with Mem_done, suppresses the
// write and returns zero on a read. When undefined, upper bits alias and
// Mem_err is tied low.
//
// State     | Meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | waiting for Read/Write; latches address, data and op on request
// ST_WAIT   | counting down wait states; leaves when the counter is at 1
// ST_ACCESS | one cycle; array write or read happens on the leaving edge
// ST_DONE   | one cycle; Mem_done high, Mdatain valid
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic          Clock,
    input  logic          clr,
    mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    op_t               r_op;

    logic              w_req;
    logic              w_start;
    logic              w_we;
    logic              w_re;
    logic              w_fault;
    logic              w_mem_err;
    logic [DATA_W-1:0] w_rdata;

    assign w_req   = bus.Read | bus.Write;
    assign w_start = (r_state == ST_IDLE) && w_req;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_re        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_nxt   = WS_INIT;
                    w_state_nxt = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // <= 1 rather than == 1 so a corrupted zero count cannot stall
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                // clr on the ACCESS edge wins: the write is not committed
                w_we        = (r_op == OP_WRITE) && !w_fault && !clr;
                w_re        = (r_op == OP_READ);
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_READ;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start) begin
                r_addr  <= bus.MAR_q[ADDR_W-1:0];
                r_wdata <= bus.MDR_q;
                r_op    <= decode_op(bus.Read, bus.Write);
            end
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic r_fault;
    logic r_mem_err;

    always_ff @(posedge Clock) begin
        if (clr) begin
            r_fault   <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_fault <= |bus.MAR_q[MAR_W-1:ADDR_W];
            end
            // high exactly for the DONE cycle that follows ACCESS
            r_mem_err <= (r_state == ST_ACCESS) && r_fault;
        end
    end

    assign w_fault   = r_fault;
    assign w_mem_err = r_mem_err;
`else
    assign w_fault   = 1'b0;
    assign w_mem_err = 1'b0;
`endif

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (Clock),
        .rst     (clr),
        .we      (w_we),
        .re      (w_re),
        .rd_zero (w_fault),
        .addr    (r_addr),
        .wdata   (r_wdata),
        .rdata   (w_rdata)
    );

    assign bus.Mdatain  = w_rdata;
    assign bus.Mem_done = (r_state == ST_DONE);
    assign bus.Mem_err  = w_mem_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders share clock and clr: u_dut2 with two wait states and u_dut0
// with none. Requests push the expected Mdatain / Mem_err / completion cycle
// into a per-DUT queue; monitors pop and compare on every Mem_done pulse.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.DATA_W(32)) b2();
    mem_responder_if #(.DATA_W(32)) b0();

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) u_dut2 (
        .Clock (clk),
        .clr   (clr),
        .bus   (b2)
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
        .Clock (clk),
        .clr   (clr),
        .bus   (b0)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (b2.Mem_done === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done2_unexpected: got Mem_done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = q2.pop_front();
                check("done2_cycle", 64'(cyc), 64'(e.cyc));
                check("mdatain2", 64'(b2.Mdatain), 64'(e.data));
                check("mem_err2", 64'(b2.Mem_err), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b0.Mem_done === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done0_unexpected: got Mem_done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = q0.pop_front();
                check("done0_cycle", 64'(cyc), 64'(e.cyc));
                check("mdatain0", 64'(b0.Mdatain), 64'(e.data));
                check("mem_err0", 64'(b0.Mem_err), 64'(e.err));
            end
        end
    end

    task automatic drain(input int which);
        int n = 0;
        while (((which == 2) ? q2.size() : q0.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (((which == 2) ? q2.size() : q0.size()) != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending responses on dut%0d expected 0",
                     (which == 2) ? q2.size() : q0.size(), which);
            if (which == 2) q2.delete(); else q0.delete();
        end
        @(negedge clk);
    endtask

    // One-cycle strobe; after the sampling edge MAR_q/MDR_q are scrambled so
    // any use of the live bus instead of the latched request shows up.
    task automatic req(input int which, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(negedge clk);
        e.data = exp_data;
        e.err  = exp_err;
        if (which == 2) begin
            b2.Read = rd; b2.Write = wr; b2.MAR_q = addr; b2.MDR_q = wdata;
            e.cyc = cyc + 2 + 2;
            q2.push_back(e);
        end else begin
            b0.Read = rd; b0.Write = wr; b0.MAR_q = addr; b0.MDR_q = wdata;
            e.cyc = cyc + 2 + 0;
            q0.push_back(e);
        end
        @(negedge clk);
        if (which == 2) begin
            b2.Read = 1'b0; b2.Write = 1'b0; b2.MAR_q = addr ^ 32'h1; b2.MDR_q = ~wdata;
        end else begin
            b0.Read = 1'b0; b0.Write = 1'b0; b0.MAR_q = addr ^ 32'h1; b0.MDR_q = ~wdata;
        end
        drain(which);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected $finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        b2.Read = 1'b0; b2.Write = 1'b0; b2.MAR_q = '0; b2.MDR_q = '0;
        b0.Read = 1'b0; b0.Write = 1'b0; b0.MAR_q = '0; b0.MDR_q = '0;

        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mdatain2", 64'(b2.Mdatain), 64'h0);
        check("rst_done2",    64'(b2.Mem_done), 64'h0);
        check("rst_err2",     64'(b2.Mem_err), 64'h0);
        check("rst_mdatain0", 64'(b0.Mdatain), 64'h0);
        check("rst_done0",    64'(b0.Mem_done), 64'h0);
        check("rst_err0",     64'(b0.Mem_err), 64'h0);
        clr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_done2", 64'(b2.Mem_done), 64'h0);
        end

        // write then read, two wait states; writes leave Mdatain alone
        req(2, 1'b0, 1'b1, 32'h010, 32'h4A920000, 32'h00000000, 1'b0);
        req(2, 1'b1, 1'b0, 32'h010, 32'h0,        32'h4A920000, 1'b0);
        // both strobes: read wins, array untouched
        req(2, 1'b1, 1'b1, 32'h010, 32'h12345678, 32'h4A920000, 1'b0);
        req(2, 1'b1, 1'b0, 32'h010, 32'h0,        32'h4A920000, 1'b0);
        // prior contents for the abort test
        req(2, 1'b0, 1'b1, 32'h020, 32'h11112222, 32'h4A920000, 1'b0);

        // abort a write during WAIT
        @(negedge clk);
        b2.Write = 1'b1; b2.MAR_q = 32'h020; b2.MDR_q = 32'hDEADBEEF;
        @(negedge clk);
        b2.Write = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_mdatain", 64'(b2.Mdatain), 64'h0);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", 64'(b2.Mem_done), 64'h0);
        end
        req(2, 1'b1, 1'b0, 32'h020, 32'h0, 32'h11112222, 1'b0);

        // zero wait states: held Read gives two transactions 3 cycles apart
        req(0, 1'b0, 1'b1, 32'h005, 32'hCAFE0001, 32'h0, 1'b0);
        req(0, 1'b0, 1'b1, 32'h006, 32'hCAFE0002, 32'h0, 1'b0);
        @(negedge clk);
        b0.Read = 1'b1; b0.MAR_q = 32'h005;
        e.err = 1'b0;
        e.data = 32'hCAFE0001; e.cyc = cyc + 2; q0.push_back(e);
        e.data = 32'hCAFE0002; e.cyc = cyc + 5; q0.push_back(e);
        @(negedge clk);
        b0.MAR_q = 32'h006;
        repeat (5) @(negedge clk);
        b0.Read = 1'b0;
        drain(0);
        repeat (3) begin
            @(negedge clk);
            check("held_no_third", 64'(b0.Mem_done), 64'h0);
        end

        // address range: 0x210 aliases 0x010 unless range checking is built in
        req(2, 1'b0, 1'b1, 32'h010, 32'h00000022, 32'h11112222, 1'b0);
`ifdef MEM_ADDR_CHECK_EN
        req(2, 1'b1, 1'b0, 32'h210, 32'h0, 32'h00000000, 1'b1);
`else
        req(2, 1'b1, 1'b0, 32'h210, 32'h0, 32'h00000022, 1'b0);
`endif
        @(negedge clk);
        check("final_err_low", 64'(b2.Mem_err), 64'h0);
        check("queues_empty", 64'(q2.size() + q0.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
